// File: rtl/ni_inject_pkg.sv
// Shared flit encodings, FSM state type and flit-type helper for the NI transmit stage.
package ni_inject_pkg;

    localparam int TYPEW = 2;

    localparam logic [TYPEW-1:0] TYPE_NONE = 2'd0;
    localparam logic [TYPEW-1:0] TYPE_HEAD = 2'd1;
    localparam logic [TYPEW-1:0] TYPE_TAIL = 2'd2;
    localparam logic [TYPEW-1:0] TYPE_DATA = 2'd3;

    typedef enum logic [1:0] {
        NI_IDLE = 2'd0,
        NI_HEAD = 2'd1,
        NI_BODY = 2'd2
    } ni_state_e;

    function automatic logic [TYPEW-1:0] body_type(input logic last);
        return last ? TYPE_TAIL : TYPE_DATA;
    endfunction

endpackage

// File: rtl/ni_credit_ctr.sv
// Per-VC credit counter: starts full, decrements on send, increments on router ack.
// An ack that finds the counter full saturates it and raises a sticky overflow flag.
module ni_credit_ctr #(
    parameter int BUF_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic send,
    input  logic ret,
    output logic can_send,
    output logic ovf
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    logic [CW-1:0] r_credit;
    logic          r_ovf;

    // Credit bookkeeping; a send and a return in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_credit <= FULL;
            r_ovf    <= 1'b0;
        end else begin
            case ({send, ret})
                2'b10: r_credit <= r_credit - CW'(1);
                2'b01: begin
                    if (r_credit == FULL) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_credit <= r_credit + CW'(1);
                    end
                end
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign can_send = (r_credit != {CW{1'b0}});
    assign ovf      = r_ovf;

endmodule

// File: rtl/ni_inject.sv
// NI transmit stage: turns a packet request plus payload words into HEAD/DATA/TAIL flits
// on one router input port, gated by per-VC credits returned through iack.
module ni_inject
    import ni_inject_pkg::*;
#(
    parameter int VCH_NUM   = 4,
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 8,
    parameter int PAY_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [PAY_W-1:0]           req_dst,
    input  logic [LEN_W-1:0]           req_len,
    input  logic [$clog2(VCH_NUM)-1:0] req_vch,
    input  logic [PAY_W-1:0]           wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [TYPEW+PAY_W-1:0]     odata,
    output logic                       ovalid,
    output logic [$clog2(VCH_NUM)-1:0] ovch,
    input  logic [VCH_NUM-1:0]         iack,
    output logic                       busy,
    output logic                       err
);

    localparam int VCHW = $clog2(VCH_NUM);
    localparam int FW   = TYPEW + PAY_W;

    ni_state_e          r_state;
    logic [PAY_W-1:0]   r_dst;
    logic [LEN_W-1:0]   r_rem;
    logic [VCHW-1:0]    r_vch;
    logic               r_req_ready;
    logic               r_busy;
    logic [FW-1:0]      r_odata;
    logic               r_ovalid;
    logic [VCHW-1:0]    r_ovch;

    logic [VCH_NUM-1:0] w_can_send;
    logic [VCH_NUM-1:0] w_ovf;
    logic [VCH_NUM-1:0] w_send;
    logic               w_cur_can;
    logic               w_head_go;
    logic               w_word_go;
    logic               w_last;

    assign w_cur_can = w_can_send[r_vch];
    assign w_last    = (r_rem == LEN_W'(1));

    // Decide whether a flit leaves this cycle and charge it to the packet's VC.
    always_comb begin
        w_send    = {VCH_NUM{1'b0}};
        w_head_go = (r_state == NI_HEAD) && w_cur_can;
        w_word_go = (r_state == NI_BODY) && w_cur_can && wvalid;
        if (w_head_go || w_word_go) begin
            w_send[r_vch] = 1'b1;
        end else begin
            w_send = {VCH_NUM{1'b0}};
        end
    end

    for (genvar v = 0; v < VCH_NUM; v++) begin : g_vc
        ni_credit_ctr #(.BUF_DEPTH(BUF_DEPTH)) u_ctr (
            .clk      (clk),
            .rst_     (rst_),
            .send     (w_send[v]),
            .ret      (iack[v]),
            .can_send (w_can_send[v]),
            .ovf      (w_ovf[v])
        );
    end

    // Packet FSM and flit output registers; odata falls back to an empty flit when idle.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state     <= NI_IDLE;
            r_dst       <= {PAY_W{1'b0}};
            r_rem       <= {LEN_W{1'b0}};
            r_vch       <= {VCHW{1'b0}};
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_odata     <= {TYPE_NONE, {PAY_W{1'b0}}};
            r_ovalid    <= 1'b0;
            r_ovch      <= {VCHW{1'b0}};
        end else begin
            r_odata  <= {TYPE_NONE, {PAY_W{1'b0}}};
            r_ovalid <= 1'b0;
            r_ovch   <= {VCHW{1'b0}};
            case (r_state)
                NI_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_dst       <= req_dst;
                        r_vch       <= req_vch;
                        // A zero length is treated as a single-word packet.
                        r_rem       <= (req_len == {LEN_W{1'b0}}) ? LEN_W'(1) : req_len;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= NI_HEAD;
                    end else begin
                        r_state <= NI_IDLE;
                    end
                end
                NI_HEAD: begin
                    if (w_head_go) begin
                        r_odata  <= {TYPE_HEAD, r_dst};
                        r_ovalid <= 1'b1;
                        r_ovch   <= r_vch;
                        r_state  <= NI_BODY;
                    end else begin
                        r_state <= NI_HEAD;
                    end
                end
                NI_BODY: begin
                    if (w_word_go) begin
                        r_odata  <= {body_type(w_last), wdata};
                        r_ovalid <= 1'b1;
                        r_ovch   <= r_vch;
                        r_rem    <= r_rem - LEN_W'(1);
                        if (w_last) begin
                            r_state     <= NI_IDLE;
                            r_busy      <= 1'b0;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state <= NI_BODY;
                        end
                    end else begin
                        r_state <= NI_BODY;
                    end
                end
                default: begin
                    r_state     <= NI_IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign wready    = (r_state == NI_BODY) && w_cur_can;
    assign odata     = r_odata;
    assign ovalid    = r_ovalid;
    assign ovch      = r_ovch;
    assign busy      = r_busy;
    assign err       = |w_ovf;

endmodule

// File: tb/tb_ni_inject.sv
// Scoreboard bench for ni_inject: expected flits are queued as packets are driven and
// matched as they leave; a credit model mirrors the router-side buffer occupancy.
module tb_ni_inject;
    import ni_inject_pkg::*;

    localparam int VCH_NUM   = 4;
    localparam int BUF_DEPTH = 4;
    localparam int LEN_W     = 8;
    localparam int PAY_W     = 32;
    localparam int TMO       = 100;

    typedef struct packed {
        logic [PAY_W+1:0] data;
        logic [1:0]       vch;
    } exp_t;

    localparam logic [PAY_W+1:0] ODATA_IDLE = {2'd0, 32'h0};

    logic               clk = 1'b0;
    logic               rst_;
    logic               req_valid;
    logic               req_ready;
    logic [PAY_W-1:0]   req_dst;
    logic [LEN_W-1:0]   req_len;
    logic [1:0]         req_vch;
    logic [PAY_W-1:0]   wdata;
    logic               wvalid;
    logic               wready;
    logic [PAY_W+1:0]   odata;
    logic               ovalid;
    logic [1:0]         ovch;
    logic [VCH_NUM-1:0] iack;
    logic               busy;
    logic               err;

    logic [VCH_NUM-1:0] auto_bits = 4'b0;
    logic [VCH_NUM-1:0] man_ack   = 4'b0;
    logic [VCH_NUM-1:0] prev_iack = 4'b0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   flit_cnt = 0;
    int   cyc      = 0;
    int   head_cyc = 0;
    int   last_flit_cyc = 0;
    int   last_req_cyc  = 0;
    int   pkts_started  = 0;
    int   pkts_done     = 0;
    int   base;
    int   t;
    logic [1:0] last_type = 2'd0;
    bit   abort    = 1'b0;
    bit   auto_ack = 1'b0;
    int   mdl_credit [VCH_NUM];

    assign iack = auto_bits | man_ack;

    ni_inject #(.VCH_NUM(VCH_NUM), .BUF_DEPTH(BUF_DEPTH), .LEN_W(LEN_W), .PAY_W(PAY_W)) dut (
        .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_len(req_len), .req_vch(req_vch),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .iack(iack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor, scoreboard pop, router credit model and automatic credit return.
    always @(negedge clk) begin
        if (rst_) begin
            for (int v = 0; v < VCH_NUM; v++) mdl_credit[v] = BUF_DEPTH;
            prev_iack = 4'b0;
            auto_bits = 4'b0;
        end else begin
            if (ovalid) begin
                flit_cnt++;
                last_flit_cyc = cyc;
                last_type = odata[PAY_W+1:PAY_W];
                if (odata[PAY_W+1:PAY_W] == TYPE_HEAD) head_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_val("spurious_flit", ovalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("flit_data", odata, mon_e.data);
                    check_val("flit_vch", ovch, mon_e.vch);
                end
                check_val("credit_nonneg", mdl_credit[ovch] > 0, 1'b1);
                mdl_credit[ovch] = mdl_credit[ovch] - 1;
            end else begin
                check_val("idle_odata", odata, ODATA_IDLE);
            end
            for (int v = 0; v < VCH_NUM; v++)
                if (prev_iack[v] && mdl_credit[v] < BUF_DEPTH) mdl_credit[v] = mdl_credit[v] + 1;
            auto_bits = (auto_ack && ovalid) ? (4'b0001 << ovch) : 4'b0000;
            prev_iack = auto_bits | man_ack;
        end
    end

    task automatic drive_packet(input logic [31:0] dst, input int len, input int vch,
                                input bit seq_words, input bit gaps);
        int   n;
        int   tw;
        exp_t e;
        logic [31:0] words[$];
        pkts_started++;
        n = (len == 0) ? 1 : len;
        e.data = {TYPE_HEAD, dst};
        e.vch  = vch[1:0];
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            words.push_back(seq_words ? 32'(i + 1) : $urandom);
            e.data = {(i == n - 1) ? TYPE_TAIL : TYPE_DATA, words[i]};
            exp_q.push_back(e);
        end
        req_dst = dst; req_len = len[7:0]; req_vch = vch[1:0]; req_valid = 1'b1;
        tw = 0;
        @(negedge clk);
        while (!req_ready && !abort && tw < TMO) begin @(negedge clk); tw++; end
        if (tw >= TMO) check_val("req_timeout", req_ready, 1'b1);
        last_req_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < n && !abort; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            wvalid = 1'b1;
            wdata  = words[i];
            tw = 0;
            @(negedge clk);
            while (!wready && !abort && tw < TMO) begin @(negedge clk); tw++; end
            if (tw >= TMO) check_val("wready_timeout", wready, 1'b1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        pkts_done++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input logic [3:0] m);
        @(posedge clk); #1 man_ack = m;
        @(posedge clk); #1 man_ack = 4'b0;
    endtask

    task automatic wait_drv();
        int tw;
        tw = 0;
        while (pkts_done != pkts_started && tw < 2 * TMO) begin @(posedge clk); tw++; end
        #1;
        if (tw >= 2 * TMO) check_val("drv_stuck", busy, 1'b0);
    endtask

    task automatic do_reset();
        abort = 1'b1;
        rst_  = 1'b1;
        req_valid = 1'b0; wvalid = 1'b0; man_ack = 4'b0; auto_ack = 1'b0;
        wait_drv();
        repeat (2) @(posedge clk);
        exp_q.delete();
        abort = 1'b0;
        #1 rst_ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit at cycle %0d, required earlier finish", cyc);
        $fatal(1);
    end

    initial begin
        rst_ = 1'b1; req_valid = 1'b0; req_dst = 32'h0; req_len = 8'h0; req_vch = 2'd0;
        wdata = 32'h0; wvalid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", req_ready, 1'b0);
        check_val("rst_ovalid", ovalid, 1'b0);
        check_val("rst_odata", odata, ODATA_IDLE);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_err", err, 1'b0);
        check_val("rst_wready", wready, 1'b0);
        @(posedge clk); #1 rst_ = 1'b0;
        wait_cyc(1);
        check_val("post_rst_req_ready", req_ready, 1'b1);

        // Basic packet, credits returned by the router model
        auto_ack = 1'b1;
        base = flit_cnt;
        drive_packet(32'h09, 4, 0, 1'b1, 1'b0);
        wait_cyc(3);
        check_val("t1_flits", flit_cnt - base, 5);
        check_val("t1_head_latency", head_cyc - last_req_cyc, 2);
        check_val("t1_back_to_back", last_flit_cyc - head_cyc, 4);
        check_val("t1_wready_low", wready, 1'b0);
        check_val("t1_busy_low", busy, 1'b0);

        // Credit stall with no returns, then released one credit at a time
        do_reset();
        base = flit_cnt;
        fork drive_packet(32'h22, 6, 0, 1'b0, 1'b0); join_none
        wait_cyc(20);
        check_val("t2_stall_flits", flit_cnt - base, 4);
        check_val("t2_stall_wready", wready, 1'b0);
        check_val("t2_stall_busy", busy, 1'b1);
        check_val("t2_stall_ovalid", ovalid, 1'b0);
        pulse_ack(4'b0001);
        pulse_ack(4'b0001);
        wait_cyc(10);
        check_val("t2_two_more", flit_cnt - base, 6);
        check_val("t2_still_busy", busy, 1'b1);
        pulse_ack(4'b0001);
        wait_cyc(10);
        check_val("t2_all_flits", flit_cnt - base, 7);
        check_val("t2_tail_last", last_type, TYPE_TAIL);
        check_val("t2_busy_done", busy, 1'b0);
        wait_drv();

        // Single-word packets on VC 2: each consumes two credits
        do_reset();
        base = flit_cnt;
        drive_packet(32'h33, 1, 2, 1'b0, 1'b0);
        wait_cyc(3);
        check_val("t3_flits", flit_cnt - base, 2);
        check_val("t3_tail", last_type, TYPE_TAIL);
        check_val("t3_busy", busy, 1'b0);
        drive_packet(32'h34, 1, 2, 1'b0, 1'b0);
        fork drive_packet(32'h35, 1, 2, 1'b0, 1'b0); join_none
        wait_cyc(10);
        check_val("t3_vc2_empty_stall", flit_cnt - base, 4);
        check_val("t3_stall_busy", busy, 1'b1);
        pulse_ack(4'b0100);
        pulse_ack(4'b0100);
        wait_cyc(10);
        check_val("t3_resume", flit_cnt - base, 6);
        wait_drv();

        // Credit overflow is sticky and does not raise the count
        do_reset();
        pulse_ack(4'b0010);
        wait_cyc(1);
        check_val("t4_err_set", err, 1'b1);
        wait_cyc(5);
        check_val("t4_err_sticky", err, 1'b1);
        base = flit_cnt;
        fork drive_packet(32'h44, 4, 1, 1'b0, 1'b0); join_none
        wait_cyc(20);
        check_val("t4_credit_saturated", flit_cnt - base, 4);
        do_reset();
        check_val("t4_err_cleared", err, 1'b0);
        // Return lands on the HEAD send edge: count stays at full, no overflow
        base = flit_cnt;
        fork drive_packet(32'h45, 4, 1, 1'b0, 1'b0); join_none
        t = 0;
        while (!busy && t < TMO) begin @(posedge clk); #1; t++; end
        man_ack = 4'b0010;
        @(posedge clk); #1 man_ack = 4'b0000;
        wait_cyc(20);
        check_val("t4_same_cycle_flits", flit_cnt - base, 5);
        check_val("t4_same_cycle_err", err, 1'b0);
        check_val("t4_same_cycle_busy", busy, 1'b0);
        wait_drv();

        // Reset while the third flit of a long packet is pending
        do_reset();
        auto_ack = 1'b1;
        base = flit_cnt;
        fork drive_packet(32'h55, 8, 0, 1'b1, 1'b0); join_none
        t = 0;
        while (flit_cnt - base < 2 && t < TMO) begin @(negedge clk); #2; t++; end
        rst_ = 1'b1;
        #1;
        check_val("t5_ovalid", ovalid, 1'b0);
        check_val("t5_odata", odata, ODATA_IDLE);
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_req_ready", req_ready, 1'b0);
        do_reset();
        base = flit_cnt;
        drive_packet(32'h56, 3, 0, 1'b0, 1'b0);
        wait_cyc(3);
        check_val("t5_clean_restart", flit_cnt - base, 4);
        check_val("t5_restart_tail", last_type, TYPE_TAIL);

        // Random traffic with credit returns and word gaps
        do_reset();
        auto_ack = 1'b1;
        for (int p = 0; p < 100; p++)
            drive_packet($urandom, $urandom_range(0, 6), $urandom_range(0, 3), 1'b0, 1'b1);
        wait_cyc(10);
        check_val("t6_queue_empty", exp_q.size(), 0);
        check_val("t6_err", err, 1'b0);
        check_val("t6_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
